wb_mcu_master: RTL

- Bridges the MCU SAM asynchronous SRAM-style bus (8-bit data, 11-bit byte address) onto the internal Wishbone bus as a Wishbone master (initiator). The MCU can then read and write any Wishbone slave register.
- Sits between the MCU pins (top level owns the tristate pad) and the Wishbone interconnect.
- Performs strobe synchronisation, 8→16-bit lane steering, single-beat Wishbone cycles, ack timeout and read-data holding.

---
 rtl/wb_mcu_master.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/wb_mcu_master.sv
// wb_mcu_master: MCU async SRAM-style bus to Wishbone master bridge.
// Synchronises strobes, steers byte lanes, one WB cycle per MCU strobe.
module wb_mcu_master #(
  parameter int ADR_WIDTH = 11,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 mcu_ncs,
  input  logic                 mcu_nwe,
  input  logic                 mcu_nrd,
  input  logic [ADR_WIDTH-1:0] mcu_addr,
  input  logic [7:0]           mcu_data_i,
  output logic [7:0]           mcu_data_o,
  output logic                 mcu_data_oe,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [ADR_WIDTH-2:0] wb_adr_o,
  output logic [15:0]          wb_dat_o,
  output logic [1:0]           wb_sel_o,
  input  logic [15:0]          wb_dat_i,
  input  logic                 wb_ack_i,
  output logic                 busy_o,
  output logic                 timeout_o,
  input  logic                 err_clr_i
);

  typedef enum logic [1:0] {IDLE, WR, RD, REL} state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t               state, state_d;
  logic [2:0]           wr_sync, rd_sync;
  logic                 wr_fall, rd_fall, released;
  logic                 cyc_d, we_d, to_d;
  logic                 clr_pend, pend_d;
  logic [ADR_WIDTH-2:0] adr_d;
  logic [15:0]          dat_d;
  logic [1:0]           sel_d;
  logic [7:0]           rdat_d;
  logic [7:0]           cnt, cnt_d, cnt_inc;

  // [0]/[1] form the synchroniser, [2] keeps history for edge detect
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_sync <= 3'b111;
      rd_sync <= 3'b111;
    end else begin
      wr_sync <= {wr_sync[1:0], mcu_ncs | mcu_nwe};
      rd_sync <= {rd_sync[1:0], mcu_ncs | mcu_nrd};
    end
  end

  assign wr_fall  = wr_sync[2] & ~wr_sync[1];
  assign rd_fall  = rd_sync[2] & ~rd_sync[1];
  assign released = wr_sync[1] & rd_sync[1];
  assign cnt_inc  = cnt + 8'd1;

  assign mcu_data_oe = !(mcu_ncs | mcu_nrd);
  assign wb_stb_o    = wb_cyc_o;
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wb_cyc_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
      mcu_data_o <= 8'h00;
      timeout_o  <= 1'b0;
      clr_pend   <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_d;
      wb_cyc_o   <= cyc_d;
      wb_we_o    <= we_d;
      wb_adr_o   <= adr_d;
      wb_dat_o   <= dat_d;
      wb_sel_o   <= sel_d;
      mcu_data_o <= rdat_d;
      timeout_o  <= to_d;
      clr_pend   <= pend_d;
      cnt        <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cyc_d   = wb_cyc_o;
    we_d    = wb_we_o;
    adr_d   = wb_adr_o;
    dat_d   = wb_dat_o;
    sel_d   = wb_sel_o;
    rdat_d  = mcu_data_o;
    to_d    = timeout_o;
    pend_d  = clr_pend;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (err_clr_i | clr_pend) begin
          to_d   = 1'b0;
          pend_d = 1'b0;
        end
        if (wr_fall | rd_fall) begin
          cyc_d   = 1'b1;
          we_d    = wr_fall;
          adr_d   = mcu_addr[ADR_WIDTH-1:1];
          sel_d   = mcu_addr[0] ? 2'b10 : 2'b01;
          cnt_d   = '0;
          state_d = wr_fall ? WR : RD;
          if (wr_fall)
            dat_d = {mcu_data_i, mcu_data_i};
        end
      end
      WR, RD: begin
        if (err_clr_i)
          pend_d = 1'b1;
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          state_d = REL;
          if (state == RD)
            rdat_d = wb_sel_o[1] ? wb_dat_i[15:8] : wb_dat_i[7:0];
        end else if (cnt_inc == TO_CNT) begin
          // a timeout outranks any clear requested alongside it
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          to_d    = 1'b1;
          pend_d  = 1'b0;
          state_d = REL;
          if (state == RD)
            rdat_d = 8'hFF;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REL: begin
        if (err_clr_i)
          pend_d = 1'b1;
        if (released)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
